branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, plus misprediction redirect logic. Sits beside the IF stage and supplies the default next-PC path to the next-PC selector: `predict_target` each cycle, and a `redirect`/`redirect_target` pair (the selector's highest-priority branch-correction input) when an EX-stage branch resolves against its prediction. Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: direction-counter encodings,
// default table size and the PC slicing helpers used for index and tag.
package branch_predictor_pkg;

   // 2-bit direction counter states; the MSB is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam int DEFAULT_ENTRIES = 16;

   // Word index of a PC, right-aligned; the caller narrows it to IDX_W bits
   function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Tag of a PC (bits above the index), right-aligned; caller narrows to TAG_W
   function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic       i_inc,
   input  logic [1:0] i_ctr,
   output logic [1:0] o_ctr
);

   // Step one state towards taken or not-taken, holding at the extremes
   always_comb begin
      o_ctr = i_ctr;
      if (i_inc) begin
         if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
      end else begin
         if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Supplies the IF-stage
// next-PC prediction and the EX-stage mispredict redirect, and keeps
// branch / mispredict statistics. Lookups are asynchronous against a
// register-based table; updates land on the rising edge.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = DEFAULT_ENTRIES
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        predict_taken,
   output logic [31:0] predict_target,
   input  logic        ex_valid,
   input  logic        ex_is_br,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        redirect,
   output logic [31:0] redirect_target,
   output logic [31:0] br_cnt,
   output logic [31:0] miss_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   // Table storage
   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];

   logic [31:0]        r_br_cnt;
   logic [31:0]        r_miss_cnt;

   // IF-side lookup
   logic [IDX_W-1:0]   w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;

   // EX-side update
   logic [IDX_W-1:0]   w_ex_idx;
   logic [TAG_W-1:0]   w_ex_tag;
   logic               w_ex_hit;
   logic               w_upd;
   logic               w_mispredict;
   logic [1:0]         w_ctr_next;

   assign w_if_idx = IDX_W'(pc_index(pc_if, IDX_W));
   assign w_if_tag = TAG_W'(pc_tag(pc_if, IDX_W));
   assign w_ex_idx = IDX_W'(pc_index(ex_pc, IDX_W));
   assign w_ex_tag = TAG_W'(pc_tag(ex_pc, IDX_W));

   // Prediction path: taken only on a tag hit with a taken-leaning counter
   always_comb begin
      w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      predict_taken  = w_if_hit && r_ctr[w_if_idx][1];
      predict_target = predict_taken ? r_target[w_if_idx] : pc_if + 32'd4;
   end

   // Resolution path: a branch redirects when direction or taken target was wrong
   always_comb begin
      w_upd           = ex_valid && ex_is_br;
      w_ex_hit        = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
      w_mispredict    = w_upd && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_pred_target != ex_target)));
      redirect        = w_mispredict;
      redirect_target = ex_taken ? ex_target : ex_pc + 32'd4;
   end

   sat_counter2 u_sat_counter2 (
      .i_inc (ex_taken),
      .i_ctr (r_ctr[w_ex_idx]),
      .o_ctr (w_ctr_next)
   );

   // Valid bits and direction counters: cleared by reset, trained on resolution
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WNT;
      end else if (w_upd) begin
         if (w_ex_hit) begin
            r_ctr[w_ex_idx] <= w_ctr_next;
         end else if (ex_taken) begin
            // Allocation overwrites whatever alias occupied the slot
            r_valid[w_ex_idx] <= 1'b1;
            r_ctr[w_ex_idx]   <= WT;
         end
      end
   end

   // Tag and target payload: no reset needed, guarded by the valid bits
   always_ff @(posedge clk) begin
      if (!rst && w_upd && ex_taken) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= ex_target;
      end
   end

   // Statistics counters, free-running modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_upd)        r_br_cnt   <= r_br_cnt + 32'd1;
         if (w_mispredict) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign br_cnt   = r_br_cnt;
   assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic,
// all compared against an abstract table model kept here.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_if;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        ex_valid;
   logic        ex_is_br;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_if           (pc_if),
      .predict_taken   (predict_taken),
      .predict_target  (predict_target),
      .ex_valid        (ex_valid),
      .ex_is_br        (ex_is_br),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .ex_pred_taken   (ex_pred_taken),
      .ex_pred_target  (ex_pred_target),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .br_cnt          (br_cnt),
      .miss_cnt        (miss_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one record per slot, counter as an integer 0..3
   bit          m_valid  [16];
   int unsigned m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   logic [31:0] m_br;
   logic [31:0] m_miss;

   function automatic int m_slot(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_slot(pc)] && (m_tag[m_slot(pc)] == int'(pc / 64));
   endfunction

   function automatic bit m_pred_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      return m_pred_taken(pc) ? m_target[m_slot(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mispredict();
      if (!(ex_valid && ex_is_br)) return 1'b0;
      if (ex_taken != ex_pred_taken) return 1'b1;
      return ex_taken && (ex_pred_target != ex_target);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_br   = 0;
      m_miss = 0;
   endtask

   task automatic m_edge();
      int s;
      if (rst) begin
         m_reset();
         return;
      end
      if (!(ex_valid && ex_is_br)) return;
      m_br = m_br + 1;
      if (m_mispredict()) m_miss = m_miss + 1;
      s = m_slot(ex_pc);
      if (m_hit(ex_pc)) begin
         if (ex_taken) begin
            m_ctr[s]    = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
            m_target[s] = ex_target;
         end else begin
            m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
         end
      end else if (ex_taken) begin
         m_valid[s]  = 1'b1;
         m_tag[s]    = int'(ex_pc / 64);
         m_target[s] = ex_target;
         m_ctr[s]    = 2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs (called just after a falling edge) and settle
   task automatic apply(input logic r, input logic [31:0] pci, input logic v, input logic br,
                        input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
      rst = r; pc_if = pci; ex_valid = v; ex_is_br = br; ex_pc = pc;
      ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
      #1;
   endtask

   task automatic idle(input logic [31:0] pci);
      apply(1'b0, pci, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Compare combinational outputs, clock once, then compare counters
   task automatic tick(input string tag);
      chk({tag, "_ptaken"}, {31'd0, predict_taken}, {31'd0, m_pred_taken(pc_if)});
      chk({tag, "_ptarget"}, predict_target, m_pred_target(pc_if));
      chk({tag, "_redir"}, {31'd0, redirect}, {31'd0, m_mispredict()});
      chk({tag, "_rtarget"}, redirect_target, ex_taken ? ex_target : ex_pc + 32'd4);
      @(posedge clk);
      m_edge();
      #1;
      chk({tag, "_brcnt"}, br_cnt, m_br);
      chk({tag, "_misscnt"}, miss_cnt, m_miss);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] pc, tgt, pci;
      logic        tk, ptk;
      logic [31:0] ptgt;
      m_reset();

      // Reset
      @(negedge clk);
      apply(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick("reset");
      idle(32'h100);
      chk("reset_ptaken", {31'd0, predict_taken}, 32'd0);
      chk("reset_ptarget", predict_target, 32'h104);
      chk("reset_br", br_cnt, 32'd0);
      chk("reset_miss", miss_cnt, 32'd0);
      tick("reset_idle");

      // Cold taken
      apply(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      chk("cold_redir", {31'd0, redirect}, 32'd1);
      chk("cold_rtarget", redirect_target, 32'h80);
      chk("cold_sameidx_ptaken", {31'd0, predict_taken}, 32'd0);
      tick("cold");
      idle(32'h100);
      chk("cold_ptaken", {31'd0, predict_taken}, 32'd1);
      chk("cold_ptarget", predict_target, 32'h80);
      chk("cold_miss", miss_cnt, 32'd1);
      tick("cold_idle");

      // Hysteresis
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
         tick("hyst_taken");
      end
      apply(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      chk("hyst_nt1_redir", {31'd0, redirect}, 32'd1);
      chk("hyst_nt1_rtarget", redirect_target, 32'h104);
      tick("hyst_nt1");
      idle(32'h100);
      chk("hyst_after1", predict_target, 32'h80);
      tick("hyst_after1");
      apply(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      tick("hyst_nt2");
      idle(32'h100);
      chk("hyst_after2", predict_target, 32'h104);
      tick("hyst_after2");

      // Alias
      apply(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick("alias_a");
      apply(1'b0, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
      tick("alias_b");
      idle(32'h100);
      chk("alias_old", predict_target, 32'h104);
      tick("alias_old");
      idle(32'h140);
      chk("alias_new", predict_target, 32'h200);
      tick("alias_new");

      // Wrong target on slot 0
      apply(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
      tick("wt_alloc");
      apply(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
      chk("wt_redir", {31'd0, redirect}, 32'd1);
      chk("wt_rtarget", redirect_target, 32'h90);
      tick("wt_upd");
      idle(32'h200);
      chk("wt_ptarget", predict_target, 32'h90);
      tick("wt_after");

      // ex_valid low with ex_is_br high: nothing changes
      apply(1'b0, 32'h200, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h90);
      chk("novalid_redir", {31'd0, redirect}, 32'd0);
      tick("novalid");
      idle(32'h200);
      chk("novalid_ptarget", predict_target, 32'h90);
      tick("novalid_after");

      // Reset collision
      apply(1'b1, 32'h240, 1'b1, 1'b1, 32'h240, 1'b1, 32'h300, 1'b0, 32'h244);
      tick("rstcol");
      idle(32'h240);
      chk("rstcol_ptaken", {31'd0, predict_taken}, 32'd0);
      chk("rstcol_br", br_cnt, 32'd0);
      tick("rstcol_a");
      idle(32'h200);
      chk("rstcol_old", predict_target, 32'h204);
      tick("rstcol_b");

      // Random traffic over an aliasing PC pool
      for (int n = 0; n < 400; n++) begin
         pc   = 32'h100 + 32'h40 * $urandom_range(0, 3) + 32'h4 * $urandom_range(0, 15);
         pci  = 32'h100 + 32'h40 * $urandom_range(0, 3) + 32'h4 * $urandom_range(0, 15);
         tk   = 1'($urandom_range(0, 1));
         tgt  = 32'h1000 + 32'h4 * $urandom_range(0, 7);
         ptk  = m_pred_taken(pc);
         ptgt = m_pred_target(pc);
         if ($urandom_range(0, 9) == 0) ptk = ~ptk;
         if ($urandom_range(0, 9) == 0) ptgt = tgt;
         apply(($urandom_range(0, 49) == 0), pci, 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), pc, tk, tgt, ptk, ptgt);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
